// File: rtl/datapath_sequencer.sv
// Single-issue sequencer: steps one decoded instruction through read, optional shift-count
// read, counted execute and one or two write-back cycles, driving datapath enables.
module datapath_sequencer #(
  parameter int ALU_LAT  = 4,
  parameter int MULT_LAT = 2,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [3:0] dec_mode,
  input  logic       dec_reg_w,
  input  logic       dec_S,
  input  logic       dec_alu_hot,
  input  logic       dec_mult_hot,
  input  logic       dec_reg_shift,
  input  logic       mem_busy,
  output logic       rb_active,
  output logic [1:0] a1_sel,
  output logic       a2_sel,
  output logic       busA_le,
  output logic       busB_le,
  output logic       shamt_le,
  output logic       alu_active,
  output logic       mult_start,
  output logic [1:0] wb_sel,
  output logic       reg_w,
  output logic       cpsr_w,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    READ2 = 3'd2,
    EXEC  = 3'd3,
    WB    = 3'd4,
    WB2   = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, lat_m1;
  logic [3:0]       mode_r;
  logic             reg_w_r, s_r, alu_r, mult_r, rsh_r;
  logic             accept, is_long, mult_e, wb_now;
  logic [1:0]       wb_a1, wb_data;

  assign accept  = instr_valid & instr_ready;
  assign is_long = mult_r & ((mode_r == 4'd2) | (mode_r == 4'd3));
  // READ outputs are decided while still in IDLE, before the capture registers load
  assign mult_e  = (state == IDLE) ? dec_mult_hot : mult_r;
  assign lat_m1  = mult_r ? CNT_W'(MULT_LAT - 1) : (alu_r ? CNT_W'(ALU_LAT - 1) : {CNT_W{1'b0}});
  assign wb_a1   = mult_r ? 2'd3 : 2'd2;
  assign wb_data = mult_r ? (is_long ? 2'd2 : 2'd3) : ((mode_r == 4'd15) ? 2'd1 : 2'd0);

  // Write strobes track mem_busy in the same cycle so a stall never leaks a write
  assign wb_now = ((state == WB) | (state == WB2)) & ~mem_busy;
  assign reg_w  = wb_now & reg_w_r;
  assign cpsr_w = wb_now & s_r & ((state == WB2) | ~is_long);
  assign done   = wb_now & ((state == WB2) | ~is_long);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) state_nxt = READ;
        else        state_nxt = IDLE;
      end
      READ: begin
        if (rsh_r & ~mult_r) begin
          state_nxt = READ2;
        end else begin
          state_nxt = EXEC;
          cnt_nxt   = lat_m1;
        end
      end
      READ2: begin
        state_nxt = EXEC;
        cnt_nxt   = lat_m1;
      end
      EXEC: begin
        if (cnt == {CNT_W{1'b0}}) state_nxt = WB;
        else                      cnt_nxt   = cnt - {{(CNT_W-1){1'b0}}, 1'b1};
      end
      WB: begin
        if (mem_busy)     state_nxt = WB;
        else if (is_long) state_nxt = WB2;
        else              state_nxt = IDLE;
      end
      WB2: begin
        if (mem_busy) state_nxt = WB2;
        else          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= {CNT_W{1'b0}};
      mode_r      <= 4'd0;
      reg_w_r     <= 1'b0;
      s_r         <= 1'b0;
      alu_r       <= 1'b0;
      mult_r      <= 1'b0;
      rsh_r       <= 1'b0;
      instr_ready <= 1'b1;
      rb_active   <= 1'b0;
      a1_sel      <= 2'd0;
      a2_sel      <= 1'b0;
      busA_le     <= 1'b0;
      busB_le     <= 1'b0;
      shamt_le    <= 1'b0;
      alu_active  <= 1'b0;
      mult_start  <= 1'b0;
      wb_sel      <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        mode_r  <= dec_mode;
        reg_w_r <= dec_reg_w;
        s_r     <= dec_S;
        alu_r   <= dec_alu_hot;
        mult_r  <= dec_mult_hot;
        rsh_r   <= dec_reg_shift;
      end else begin
        mode_r  <= mode_r;
        reg_w_r <= reg_w_r;
        s_r     <= s_r;
        alu_r   <= alu_r;
        mult_r  <= mult_r;
        rsh_r   <= rsh_r;
      end
      // Enables are decoded from the next state so they are registered yet aligned
      instr_ready <= (state_nxt == IDLE);
      rb_active   <= (state_nxt == READ) | (state_nxt == READ2) |
                     (state_nxt == WB)   | (state_nxt == WB2);
      busA_le     <= (state_nxt == READ);
      busB_le     <= (state_nxt == READ);
      shamt_le    <= (state_nxt == READ2);
      alu_active  <= (state_nxt == EXEC) & alu_r & ~mult_r;
      mult_start  <= (state_nxt == EXEC) & (state != EXEC) & mult_r;
      case (state_nxt)
        READ: begin
          a1_sel <= mult_e ? 2'd1 : 2'd0;
          a2_sel <= ~mult_e;
          wb_sel <= 2'd0;
        end
        WB: begin
          a1_sel <= wb_a1;
          a2_sel <= 1'b0;
          wb_sel <= wb_data;
        end
        WB2: begin
          a1_sel <= 2'd2;
          a2_sel <= 1'b0;
          wb_sel <= 2'd3;
        end
        default: begin
          a1_sel <= 2'd0;
          a2_sel <= 1'b0;
          wb_sel <= 2'd0;
        end
      endcase
    end
  end

endmodule
